// File: rtl/climate_sample_sequencer_if.sv
// rtl/climate_sample_sequencer_if.sv - sample, predictor and result signals of the climate sample sequencer
//
// Purpose: groups every handshake/bus signal of climate_sample_sequencer.
//   master : the sequencer (drives sample_ready, temperature, pressure,
//            result_valid, result_condition, result_timeout, busy)
//   slave  : the environment (sample source, predictor and result consumer)
// Signals:
//   sample_valid/sample_ready/sample_temp/sample_press : raw sample stream
//   temperature/pressure                               : averaged inputs to predictor
//   climate_condition/done                             : predictor answer
//   result_valid/result_ready/result_condition/result_timeout : result port
//   busy                                               : sequencer not accumulating

interface climate_sample_sequencer_if;
    logic               sample_valid;
    logic               sample_ready;
    logic signed [31:0] sample_temp;
    logic        [31:0] sample_press;
    logic signed [31:0] temperature;
    logic        [31:0] pressure;
    logic        [31:0] climate_condition;
    logic               done;
    logic               result_valid;
    logic               result_ready;
    logic        [31:0] result_condition;
    logic               result_timeout;
    logic               busy;

    modport master (
        input  sample_valid, sample_temp, sample_press,
        input  climate_condition, done, result_ready,
        output sample_ready, temperature, pressure,
        output result_valid, result_condition, result_timeout, busy
    );

    modport slave (
        output sample_valid, sample_temp, sample_press,
        output climate_condition, done, result_ready,
        input  sample_ready, temperature, pressure,
        input  result_valid, result_condition, result_timeout, busy
    );
endinterface

// File: rtl/climate_sample_sequencer.sv
// rtl/climate_sample_sequencer.sv - windowed sample averager that drives the climate predictor and reports its answer
//
// Purpose: averages each window of 2^LOG2_AVG samples, clamps the pressure
// average to PRESS_MAX, presents the averages to the predictor, waits up to
// TIMEOUT cycles for done and returns climate_condition (or a timeout flag)
// over a valid/ready result port.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : climate_sample_sequencer_if.master (sample stream, predictor
//          inputs/outputs, result port, busy)

module climate_sample_sequencer #(
    parameter int LOG2_AVG  = 2,
    parameter int PRESS_MAX = 2047,
    parameter int TIMEOUT   = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    climate_sample_sequencer_if.master    bus
);

    localparam int AW  = 32 + LOG2_AVG;
    localparam int WIN = 1 << LOG2_AVG;
    localparam int CW  = LOG2_AVG + 1;
    localparam int WW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [AW-1:0] temp_acc;
    logic        [AW-1:0] press_acc;
    logic        [AW-1:0] press_avg;
    logic        [CW-1:0] cnt;
    logic        [WW-1:0] wait_cnt;

    // Cleared by reset, set on the first clock afterwards: keeps sample_ready
    // low while rst is asserted even though the FSM already sits in ACCUM.
    logic armed;

    logic               sample_ready_c;
    logic               result_valid_c;
    logic               busy_c;
    logic               accept;
    logic               issue;
    logic               wait_inc;
    logic               done_hit;
    logic               timeout_hit;

    logic signed [31:0] temperature_q;
    logic        [31:0] pressure_q;
    logic        [31:0] result_condition_q;
    logic               result_timeout_q;

    assign press_avg = press_acc >> LOG2_AVG;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        sample_ready_c = 1'b0;
        result_valid_c = 1'b0;
        busy_c         = 1'b1;
        accept         = 1'b0;
        issue          = 1'b0;
        wait_inc       = 1'b0;
        done_hit       = 1'b0;
        timeout_hit    = 1'b0;
        case (state)
            ACCUM: begin
                busy_c         = 1'b0;
                sample_ready_c = armed;
                if (bus.sample_valid && armed) begin
                    accept = 1'b1;
                    if (cnt == CW'(WIN - 1)) begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                issue      = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // done wins over a timeout reached in the same cycle
                if (bus.done) begin
                    done_hit   = 1'b1;
                    state_next = REPORT;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = REPORT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            REPORT: begin
                result_valid_c = 1'b1;
                if (bus.result_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed              <= 1'b0;
            temp_acc           <= '0;
            press_acc          <= '0;
            cnt                <= '0;
            wait_cnt           <= '0;
            temperature_q      <= '0;
            pressure_q         <= '0;
            result_condition_q <= '0;
            result_timeout_q   <= 1'b0;
        end else begin
            armed <= 1'b1;

            if (accept) begin
                // sign-extend temperature, zero-extend pressure into the wide sums
                temp_acc  <= temp_acc + AW'(bus.sample_temp);
                press_acc <= press_acc + AW'(bus.sample_press);
                cnt       <= cnt + CW'(1);
            end

            if (issue) begin
                // >>> on the signed sum floors toward minus infinity
                temperature_q <= 32'(temp_acc >>> LOG2_AVG);
                pressure_q    <= (press_avg > AW'(PRESS_MAX)) ? 32'(PRESS_MAX)
                                                              : 32'(press_avg);
                temp_acc      <= '0;
                press_acc     <= '0;
                cnt           <= '0;
                wait_cnt      <= '0;
            end

            if (wait_inc) begin
                wait_cnt <= wait_cnt + WW'(1);
            end

            if (done_hit) begin
                result_condition_q <= bus.climate_condition;
                result_timeout_q   <= 1'b0;
            end

            if (timeout_hit) begin
                result_condition_q <= '0;
                result_timeout_q   <= 1'b1;
            end
        end
    end

    assign bus.sample_ready     = sample_ready_c;
    assign bus.result_valid     = result_valid_c;
    assign bus.busy             = busy_c;
    assign bus.temperature      = temperature_q;
    assign bus.pressure         = pressure_q;
    assign bus.result_condition = result_condition_q;
    assign bus.result_timeout   = result_timeout_q;

endmodule

// File: tb/tb_climate_sample_sequencer.sv
// tb/tb_climate_sample_sequencer.sv - self-checking bench for climate_sample_sequencer

module tb_climate_sample_sequencer;

    localparam int LOG2 = 2;
    localparam int N    = 4;
    localparam int PMAX = 2047;
    localparam int TO   = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    climate_sample_sequencer_if bus ();

    climate_sample_sequencer #(
        .LOG2_AVG  (LOG2),
        .PRESS_MAX (PMAX),
        .TIMEOUT   (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // floor(sum/N) using plain integer arithmetic
    function automatic logic [31:0] exp_temp(input logic [31:0] t[4]);
        longint s;
        longint q;
        logic [63:0] qv;
        s = 0;
        for (int i = 0; i < N; i++) s += longint'($signed(t[i]));
        q = s / N;
        if ((s % N != 0) && (s < 0)) q = q - 1;
        qv = q;
        return qv[31:0];
    endfunction

    function automatic logic [31:0] exp_press(input logic [31:0] p[4]);
        longint unsigned s;
        longint unsigned q;
        logic [63:0] qv;
        s = 0;
        for (int i = 0; i < N; i++) s += longint'(p[i]);
        q = s / N;
        if (q > PMAX) q = PMAX;
        qv = q;
        return qv[31:0];
    endfunction

    task automatic push(input logic [31:0] t, input logic [31:0] p, input int gap, output int edge_no);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.sample_valid = 1'b0;
            bus.sample_temp  = $urandom;
            bus.sample_press = $urandom;
        end
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample_temp  = t;
        bus.sample_press = p;
        for (int g = 0; g < 50 && !bus.sample_ready; g++) @(negedge clk);
        @(posedge clk);
        #1;
        edge_no = cyc;
    endtask

    // One full window. done is pulsed in WAIT cycle d (1-based), or held high
    // throughout when hold_done is set; d greater than TO means never.
    task automatic run_window(input string name, input logic [31:0] t[4], input logic [31:0] p[4],
                              input int gap, input int d, input bit hold_done, input int hold_cycles);
        int          k;
        int          rise;
        int          exp_w;
        int          exp_lat;
        logic [31:0] cc;
        logic [31:0] exp_cond;
        logic        exp_to;
        bus.result_ready = 1'b0;
        bus.done         = hold_done;
        for (int i = 0; i < N; i++) push(t[i], p[i], gap, k);
        rise     = -1;
        exp_w    = -1;
        exp_cond = '0;
        for (int j = 1; j <= TO + 8; j++) begin
            @(negedge clk);
            if (bus.result_valid) begin
                rise = cyc;
                break;
            end
            // keep offering junk samples: none may be accepted outside ACCUM
            bus.sample_valid      = 1'b1;
            bus.sample_temp       = $urandom;
            bus.sample_press      = $urandom;
            cc                    = $urandom;
            bus.climate_condition = cc;
            bus.done              = hold_done || (j - 1 == d);
            if (j >= 2 && bus.done && exp_w < 0 && j - 1 <= TO) begin
                exp_w    = j - 1;
                exp_cond = cc;
            end
        end
        if (exp_w < 0) begin
            exp_lat  = 1 + TO;
            exp_cond = '0;
            exp_to   = 1'b1;
        end else begin
            exp_lat = 1 + exp_w;
            exp_to  = 1'b0;
        end
        total++;
        if (rise < 0) begin
            $display("FAIL %s result_valid: never rose, required after %0d cycles", name, exp_lat);
        end else begin
            passed++;
            total++;
            if ((rise - k) !== exp_lat) $display("FAIL %s latency: got %0d required %0d", name, rise - k, exp_lat);
            else passed++;
            total++;
            if (bus.result_condition !== exp_cond)
                $display("FAIL %s result_condition: got %h required %h", name, bus.result_condition, exp_cond);
            else passed++;
            total++;
            if (bus.result_timeout !== exp_to)
                $display("FAIL %s result_timeout: got %b required %b", name, bus.result_timeout, exp_to);
            else passed++;
            total++;
            if (bus.temperature !== exp_temp(t))
                $display("FAIL %s temperature: got %h required %h", name, bus.temperature, exp_temp(t));
            else passed++;
            total++;
            if (bus.pressure !== exp_press(p))
                $display("FAIL %s pressure: got %h required %h", name, bus.pressure, exp_press(p));
            else passed++;
            total++;
            if ({bus.busy, bus.sample_ready} !== 2'b10)
                $display("FAIL %s busy/sample_ready in REPORT: got %b required 10", name, {bus.busy, bus.sample_ready});
            else passed++;
            for (int h = 0; h < hold_cycles; h++) begin
                @(negedge clk);
                bus.sample_temp  = $urandom;
                bus.sample_press = $urandom;
                total++;
                if ({bus.result_valid, bus.sample_ready, bus.result_timeout, bus.result_condition} !==
                    {1'b1, 1'b0, exp_to, exp_cond})
                    $display("FAIL %s hold cycle %0d: got v=%b r=%b to=%b c=%h required v=1 r=0 to=%b c=%h",
                             name, h, bus.result_valid, bus.sample_ready, bus.result_timeout,
                             bus.result_condition, exp_to, exp_cond);
                else passed++;
            end
        end
        bus.result_ready = 1'b1;
        bus.sample_valid = 1'b0;
        bus.done         = hold_done;
        @(posedge clk);
        @(negedge clk);
        bus.result_ready = 1'b0;
        total++;
        if ({bus.result_valid, bus.sample_ready, bus.busy} !== 3'b010)
            $display("FAIL %s after handshake valid/ready/busy: got %b required 010", name,
                     {bus.result_valid, bus.sample_ready, bus.busy});
        else passed++;
        total++;
        if (bus.temperature !== exp_temp(t))
            $display("FAIL %s temperature held: got %h required %h", name, bus.temperature, exp_temp(t));
        else passed++;
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({bus.sample_ready, bus.temperature, bus.pressure, bus.result_valid,
             bus.result_condition, bus.result_timeout, bus.busy} !== '0)
            $display("FAIL %s outputs under reset: got rdy=%b t=%h p=%h v=%b c=%h to=%b busy=%b required all 0",
                     name, bus.sample_ready, bus.temperature, bus.pressure, bus.result_valid,
                     bus.result_condition, bus.result_timeout, bus.busy);
        else passed++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (bus.sample_ready !== 1'b0) $display("FAIL reset ready before edge: got %b required 0", bus.sample_ready);
        else passed++;
        @(negedge clk);
        total++;
        if ({bus.sample_ready, bus.busy, bus.result_valid} !== 3'b100)
            $display("FAIL reset ready after edge: got %b required 100", {bus.sample_ready, bus.busy, bus.result_valid});
        else passed++;
    endtask

    task automatic test_basic;
        logic [31:0] t[4];
        logic [31:0] p[4];
        t = '{32'd10, 32'd20, 32'd30, 32'd40};
        p = '{32'd1000, 32'd1000, 32'd1000, 32'd1000};
        bus.climate_condition = 32'd5;
        run_window("basic", t, p, 0, 3, 1'b0, 0);
    endtask

    task automatic test_rounding_clamp;
        logic [31:0] t[4];
        logic [31:0] p[4];
        t = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        p = '{32'd3000, 32'd3000, 32'd3000, 32'd3000};
        run_window("floor_clamp", t, p, 0, 1, 1'b0, 0);
        t = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        p = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        run_window("max_pos", t, p, 0, 2, 1'b0, 0);
        t = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        p = '{32'd2047, 32'd2048, 32'd2047, 32'd2047};
        run_window("max_neg", t, p, 0, 1, 1'b0, 0);
    endtask

    task automatic test_timeout;
        logic [31:0] t[4];
        logic [31:0] p[4];
        t = '{32'd1, 32'd2, 32'd3, 32'd4};
        p = '{32'd5, 32'd6, 32'd7, 32'd8};
        run_window("timeout", t, p, 0, TO + 5, 1'b0, 0);
        run_window("done_at_timeout", t, p, 0, TO, 1'b0, 0);
    endtask

    task automatic test_gaps_and_hold;
        logic [31:0] t[4];
        logic [31:0] p[4];
        t = '{32'd100, 32'hFFFF_FF9C, 32'd7, 32'd13};
        p = '{32'd400, 32'd800, 32'd1200, 32'd1600};
        run_window("gaps_hold", t, p, 1, 4, 1'b0, 5);
        t = '{32'd3, 32'd3, 32'd3, 32'd3};
        p = '{32'd9, 32'd9, 32'd9, 32'd9};
        run_window("after_hold", t, p, 0, 1, 1'b0, 0);
    endtask

    task automatic test_reset_mid;
        logic [31:0] t[4];
        logic [31:0] p[4];
        int k;
        bus.done = 1'b0;
        for (int i = 0; i < N; i++) push(32'd100 + i, 32'd500, 0, k);
        bus.sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_wait");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push(32'd1000, 32'd1000, 0, k);
        push(32'd1000, 32'd1000, 0, k);
        bus.sample_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_partial");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        t = '{32'd8, 32'd8, 32'd8, 32'd8};
        p = '{32'd8, 32'd8, 32'd8, 32'd8};
        run_window("after_reset", t, p, 0, 2, 1'b0, 0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] t[4];
        logic [31:0] p[4];
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < N; i++) begin
                t[i] = $urandom;
                p[i] = $urandom_range(0, 3000);
            end
            run_window("back_to_back", t, p, 0, 1, 1'b1, 0);
        end
        bus.done = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] t[4];
        logic [31:0] p[4];
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < N; i++) begin
                t[i] = $urandom;
                p[i] = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 4000);
            end
            run_window("random", t, p, $urandom_range(0, 2), $urandom_range(1, TO + 2), 1'b0,
                       $urandom_range(0, 3));
        end
    endtask

    initial begin
        bus.sample_valid      = 1'b0;
        bus.sample_temp       = '0;
        bus.sample_press      = '0;
        bus.climate_condition = '0;
        bus.done              = 1'b0;
        bus.result_ready      = 1'b0;
        rst                   = 1'b1;
        test_reset();
        test_basic();
        test_rounding_clamp();
        test_timeout();
        test_gaps_and_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
